// File: rtl/clock_ctrl_pkg.sv
// Shared types and limits for the board time-of-day controller.
// Mode encoding matches the o_mode output seen by the display driver.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetHr  = 2'd1,
        StSetMin = 2'd2
    } mode_e;

    localparam logic [4:0] HR_MAX = 5'd23;
    localparam logic [5:0] MS_MAX = 6'd59;

    // Bits needed to hold 0 .. max_count-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/clock_ctrl_btn_debounce.sv
// Push-button front end: 2-flop synchroniser, debounce sampled on the 120 Hz strobe,
// single-cycle press strobe on an accepted 0->1 change.
module clock_ctrl_btn_debounce
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 3
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_tick_f,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_TICKS);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_TICKS - 1);

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], i_btn};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample matching the accepted level restarts the run of differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (i_tick_f) begin
            if (sync_q[1] == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntLast) begin
                accept  = 1'b1;
                level_d = sync_q[1];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // o_level already reflects an acceptance happening this cycle.
    assign o_level = level_d;
    assign o_press = accept & sync_q[1];

endmodule

// File: rtl/clock_ctrl.sv
// Time-of-day controller: HH:MM:SS counters, RUN/SET_HR/SET_MIN mode machine,
// UP auto-repeat and blink phase for the field being set.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 3,
    parameter int unsigned HOLD_TICKS     = 60,
    parameter int unsigned REPEAT_TICKS   = 12,
    parameter int unsigned BLINK_TICKS    = 30
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_tick_n,
    input  logic       i_tick_f,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic [5:0] o_seconds,
    output logic [1:0] o_mode,
    output logic       o_blink
);

    localparam int unsigned RepW =
        cnt_width((HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS);
    localparam logic [RepW-1:0] HoldLast   = RepW'(HOLD_TICKS - 1);
    localparam logic [RepW-1:0] RepeatLast = RepW'(REPEAT_TICKS - 1);
    localparam int unsigned BlinkW = cnt_width(BLINK_TICKS);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_TICKS - 1);

    logic mode_press, up_press, up_level, unused_mode_level;

    clock_ctrl_btn_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_mode_db (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_tick_f (i_tick_f),
        .i_btn    (i_btn_mode),
        .o_level  (unused_mode_level),
        .o_press  (mode_press)
    );

    clock_ctrl_btn_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_up_db (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_tick_f (i_tick_f),
        .i_btn    (i_btn_up),
        .o_level  (up_level),
        .o_press  (up_press)
    );

    mode_e             state_q, state_d;
    logic [4:0]        hours_q, hours_d;
    logic [5:0]        minutes_q, minutes_d;
    logic [5:0]        seconds_q, seconds_d;
    logic [RepW-1:0]   rep_cnt_q, rep_cnt_d;
    logic              rep_phase_q, rep_phase_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;
    logic              up_inc;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= StRun;
            hours_q     <= '0;
            minutes_q   <= '0;
            seconds_q   <= '0;
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (mode_press) state_d = StSetHr;
            StSetHr:  if (mode_press) state_d = StSetMin;
            StSetMin: if (mode_press) state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    // Auto-repeat: hold phase (rep_phase_q=0) then periodic phase until release.
    always_comb begin
        up_inc      = 1'b0;
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        if (up_press) begin
            up_inc      = 1'b1;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (!up_level) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (i_tick_f) begin
            if ((!rep_phase_q && rep_cnt_q == HoldLast) ||
                (rep_phase_q && rep_cnt_q == RepeatLast)) begin
                up_inc      = 1'b1;
                rep_cnt_d   = '0;
                rep_phase_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        unique case (state_q)
            StRun: begin
                if (i_tick_n) begin
                    if (seconds_q == MS_MAX) begin
                        seconds_d = '0;
                        if (minutes_q == MS_MAX) begin
                            minutes_d = '0;
                            hours_d   = (hours_q == HR_MAX) ? 5'd0 : hours_q + 5'd1;
                        end else begin
                            minutes_d = minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_d = seconds_q + 6'd1;
                    end
                end
            end
            StSetHr: begin
                if (up_inc) hours_d = (hours_q == HR_MAX) ? 5'd0 : hours_q + 5'd1;
            end
            StSetMin: begin
                if (up_inc) minutes_d = (minutes_q == MS_MAX) ? 6'd0 : minutes_q + 6'd1;
                if (mode_press) seconds_d = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (state_d != state_q || state_q == StRun) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (i_tick_f) begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    assign o_hours   = hours_q;
    assign o_minutes = minutes_q;
    assign o_seconds = seconds_q;
    assign o_mode    = state_q;
    assign o_blink   = blink_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: table of RUN-mode vectors plus hand sequences
// for set mode, debounce, auto-repeat, wraps, simultaneous events and reset.
module tb_clock_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_n = 1'b0;
    logic       tick_f = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clock_ctrl dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_tick_n  (tick_n),
        .i_tick_f  (tick_f),
        .i_btn_mode(btn_mode),
        .i_btn_up  (btn_up),
        .o_hours   (hours),
        .o_minutes (minutes),
        .o_seconds (seconds),
        .o_mode    (mode),
        .o_blink   (blink)
    );

    typedef struct {
        int   n_fast;
        int   n_tick;
        logic up;
        int   h;
        int   m;
        int   s;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hours"}, int'(hours), h);
        check({tag, "_minutes"}, int'(minutes), m);
        check({tag, "_seconds"}, int'(seconds), s);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_f(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_f = 1'b1;
            @(negedge clk) tick_f = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_n = 1'b1;
            @(negedge clk) tick_n = 1'b0;
        end
    endtask

    // Raw buttons high for 'samples' 120 Hz samples, then released and debounced low.
    task automatic press(input logic m, input logic u, input int samples);
        btn_mode = m;
        btn_up   = u;
        wait_clk(3);
        pulse_f(samples);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        wait_clk(3);
        pulse_f(3);
    endtask

    task automatic press_up(input int n);
        for (int i = 0; i < n; i++) press(1'b0, 1'b1, 3);
    endtask

    initial begin
        vecs[0] = '{n_fast: 0,  n_tick: 3,  up: 1'b0, h: 0, m: 0, s: 3};
        vecs[1] = '{n_fast: 70, n_tick: 2,  up: 1'b1, h: 0, m: 0, s: 5};
        vecs[2] = '{n_fast: 4,  n_tick: 57, up: 1'b0, h: 0, m: 1, s: 2};

        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(1);
        check_time("reset", 0, 0, 0);
        check("reset_mode", int'(mode), 0);
        check("reset_blink", int'(blink), 0);

        // RUN mode vectors; UP is held through row 1 and must be ignored
        for (int v = 0; v < 3; v++) begin
            btn_up = vecs[v].up;
            wait_clk(3);
            pulse_f(vecs[v].n_fast);
            pulse_n(vecs[v].n_tick);
            check_time($sformatf("run_vec%0d", v), vecs[v].h, vecs[v].m, vecs[v].s);
            check($sformatf("run_vec%0d_mode", v), int'(mode), 0);
            check($sformatf("run_vec%0d_blink", v), int'(blink), 0);
        end

        // Enter SET_HR; time frozen; blink toggles on the 30th tick after entry
        press(1'b1, 1'b0, 3);
        check("set_hr_mode", int'(mode), 1);
        check("set_hr_blink_entry", int'(blink), 0);
        pulse_n(3);
        check_time("set_hr_frozen", 0, 1, 2);
        pulse_f(26);
        check("blink_tick29", int'(blink), 0);
        pulse_f(1);
        check("blink_tick30", int'(blink), 1);

        press_up(23);
        check("hours_23", int'(hours), 23);
        press_up(1);
        check_time("hours_wrap", 0, 1, 2);
        press_up(23);

        // SET_MIN: debounce glitch, single press, auto-repeat
        press(1'b1, 1'b0, 3);
        check("set_min_mode", int'(mode), 2);
        press(1'b0, 1'b1, 2);
        check("glitch_2_samples", int'(minutes), 1);
        press(1'b0, 1'b1, 3);
        check("glitch_3_samples", int'(minutes), 2);
        press_up(8);
        check("minutes_10", int'(minutes), 10);

        btn_up = 1'b1;
        wait_clk(3);
        pulse_f(120);
        check("repeat_held", int'(minutes), 16);
        btn_up = 1'b0;
        wait_clk(3);
        pulse_f(3);
        check("repeat_released", int'(minutes), 16);

        press_up(43);
        check("minutes_59", int'(minutes), 59);
        press_up(1);
        check_time("minutes_wrap_nocarry", 23, 0, 2);
        press_up(58);
        pulse_n(2);
        check_time("set_min_frozen", 23, 58, 2);

        // MODE and UP accepted together: increment hits minutes, then RUN with seconds cleared
        press(1'b1, 1'b1, 3);
        check("exit_mode", int'(mode), 0);
        check("exit_blink", int'(blink), 0);
        check_time("exit_set_min", 23, 59, 0);

        pulse_n(58);
        check_time("pre_midnight", 23, 59, 58);
        pulse_n(1);
        check_time("one_to_midnight", 23, 59, 59);
        pulse_n(1);
        check_time("midnight", 0, 0, 0);

        // Set 12:00:00
        press(1'b1, 1'b0, 3);
        press_up(12);
        press(1'b1, 1'b0, 3);
        press(1'b1, 1'b0, 3);
        check_time("noon", 12, 0, 0);
        check("noon_mode", int'(mode), 0);

        // Second tick coincides with the accepting MODE sample
        btn_mode = 1'b1;
        wait_clk(3);
        pulse_f(2);
        @(negedge clk) begin
            tick_f = 1'b1;
            tick_n = 1'b1;
        end
        @(negedge clk) begin
            tick_f = 1'b0;
            tick_n = 1'b0;
        end
        check_time("tick_and_mode", 12, 0, 1);
        check("tick_and_mode_mode", int'(mode), 1);
        btn_mode = 1'b0;
        wait_clk(3);
        pulse_f(3);
        pulse_n(4);
        check_time("frozen_after_simul", 12, 0, 1);

        // 07:42 in SET_MIN, then a one-cycle reset
        press_up(19);
        press(1'b1, 1'b0, 3);
        press_up(42);
        check_time("pre_reset", 7, 42, 1);
        check("pre_reset_mode", int'(mode), 2);
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        check_time("mid_set_reset", 0, 0, 0);
        check("mid_set_reset_mode", int'(mode), 0);
        check("mid_set_reset_blink", int'(blink), 0);
        pulse_n(1);
        check_time("post_reset_tick", 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
